// File: rtl/rv32m_div_unit_if.sv
// Request/response bundle between the EX stage and the iterative divider.
interface rv32m_div_unit_if #(
    parameter int unsigned XLEN = 32
);
    logic            start;
    logic [1:0]      op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            flush;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (
        output start, op, a, b, flush,
        input  busy, done, result
    );

    modport slave (
        input  start, op, a, b, flush,
        output busy, done, result
    );
endinterface

// File: rtl/rv32m_div_unit.sv
// Radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU, one quotient bit per cycle.
module rv32m_div_unit #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 6
) (
    input logic             clk,
    input logic             rst,
    rv32m_div_unit_if.slave div_if
);
    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e            state_q, state_d;
    logic [1:0]        op_q, op_d;
    logic [XLEN-1:0]   rem_q, rem_d;
    logic [XLEN-1:0]   quo_q, quo_d;
    logic [XLEN-1:0]   dvs_q, dvs_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              sgn_quo_q, sgn_quo_d;
    logic              sgn_rem_q, sgn_rem_d;
    logic [XLEN-1:0]   result_q, result_d;

    logic              accept, signed_op, a_neg, b_neg, div_zero, overflow, special, last_iter;
    logic [XLEN-1:0]   a_mag, b_mag, quo_fix, rem_fix, final_res;
    logic [XLEN:0]     trial;

    assign accept    = (state_q == StIdle) && div_if.start && !div_if.flush;
    assign signed_op = ~div_if.op[0];
    assign a_neg     = signed_op & div_if.a[XLEN-1];
    assign b_neg     = signed_op & div_if.b[XLEN-1];
    assign a_mag     = a_neg ? -div_if.a : div_if.a;
    assign b_mag     = b_neg ? -div_if.b : div_if.b;
    assign div_zero  = (div_if.b == '0);
    assign overflow  = signed_op && (div_if.a == {1'b1, {(XLEN-1){1'b0}}}) && (div_if.b == '1);
    assign special   = div_zero | overflow;
    assign last_iter = (cnt_q == CNT_W'(XLEN-1));

    // Shifted partial remainder needs XLEN+1 bits; a borrow in the top bit means "restore".
    assign trial     = {rem_q, quo_q[XLEN-1]} - {1'b0, dvs_q};

    assign quo_fix   = (sgn_quo_q && !op_q[0]) ? -quo_q : quo_q;
    assign rem_fix   = (sgn_rem_q && !op_q[0]) ? -rem_q : rem_q;
    assign final_res = op_q[1] ? rem_fix : quo_fix;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (accept) state_d = special ? StDone : StCalc;
            StCalc: begin
                if (div_if.flush)   state_d = StIdle;
                else if (last_iter) state_d = StDone;
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        div_if.busy   = (state_q != StIdle);
        div_if.done   = (state_q == StDone) && !div_if.flush;
        div_if.result = div_if.done ? final_res : result_q;
    end

    always_comb begin
        op_d      = op_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvs_d     = dvs_q;
        cnt_d     = cnt_q;
        sgn_quo_d = sgn_quo_q;
        sgn_rem_d = sgn_rem_q;
        result_d  = result_q;
        if (accept) begin
            op_d      = div_if.op;
            cnt_d     = '0;
            dvs_d     = b_mag;
            sgn_quo_d = 1'b0;
            sgn_rem_d = 1'b0;
            // Special cases preload the final quotient/remainder and skip CALC.
            if (div_zero) begin
                quo_d = '1;
                rem_d = div_if.a;
            end else if (overflow) begin
                quo_d = {1'b1, {(XLEN-1){1'b0}}};
                rem_d = '0;
            end else begin
                quo_d     = a_mag;
                rem_d     = '0;
                sgn_quo_d = a_neg ^ b_neg;
                sgn_rem_d = a_neg;
            end
        end else if (state_q == StCalc) begin
            rem_d = trial[XLEN] ? {rem_q[XLEN-2:0], quo_q[XLEN-1]} : trial[XLEN-1:0];
            quo_d = {quo_q[XLEN-2:0], ~trial[XLEN]};
            cnt_d = cnt_q + 1'b1;
        end else if (div_if.done) begin
            result_d = final_res;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q      <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            cnt_q     <= '0;
            sgn_quo_q <= 1'b0;
            sgn_rem_q <= 1'b0;
            result_q  <= '0;
        end else begin
            op_q      <= op_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvs_q     <= dvs_d;
            cnt_q     <= cnt_d;
            sgn_quo_q <= sgn_quo_d;
            sgn_rem_q <= sgn_rem_d;
            result_q  <= result_d;
        end
    end
endmodule
